// File: rtl/ctr_queue_checker.sv
// ctr_queue_checker: relational contract checker for two lock-stepped copies
// of a core. Each copy pushes its retirement observation into a private FIFO;
// heads are compared and popped together once both FIFOs hold an entry.
// Sticky diagnostics (equivalence, first mismatch, overflow, count mismatch)
// and the peak occupancy skew are reported as registered outputs.
// Optional feature: define CTR_MISMATCH_TRACE_EN to capture the first
// mismatching pair on mismatch_obs_1_o / mismatch_obs_2_o.
module ctr_queue_checker #(
   parameter int OBS_W = 64,
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       retire_1_i,
   input  logic [OBS_W-1:0]           obs_1_i,
   input  logic                       retire_2_i,
   input  logic [OBS_W-1:0]           obs_2_i,
   input  logic                       done_i,
   output logic                       ctr_equiv_o,
   output logic                       mismatch_valid_o,
   output logic [CNT_W-1:0]           mismatch_idx_o,
   output logic [CNT_W-1:0]           compared_cnt_o,
   output logic                       overflow_o,
   output logic                       count_mismatch_o,
   output logic [$clog2(DEPTH):0]     max_skew_o,
   output logic [OBS_W-1:0]           mismatch_obs_1_o,
   output logic [OBS_W-1:0]           mismatch_obs_2_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int SW = AW + 1;
   localparam logic [SW-1:0]    FULL_OCC = SW'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // FIFO storage and bookkeeping
   logic [OBS_W-1:0] mem_1_q [DEPTH];
   logic [OBS_W-1:0] mem_2_q [DEPTH];
   logic [AW-1:0]    wr_1_q, wr_1_d, rd_1_q, rd_1_d;
   logic [AW-1:0]    wr_2_q, wr_2_d, rd_2_q, rd_2_d;
   logic [SW-1:0]    occ_1_q, occ_1_d, occ_2_q, occ_2_d;

   // Diagnostic state
   logic             equiv_q, equiv_d;
   logic             mm_valid_q, mm_valid_d;
   logic [CNT_W-1:0] mm_idx_q, mm_idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             overflow_q, overflow_d;
   logic             count_mm_q, count_mm_d;
   logic [SW-1:0]    max_skew_q, max_skew_d;

   // Per-cycle control
   logic             pop;
   logic             push_1, push_2;
   logic             drop_1, drop_2;
   logic             heads_differ;
   logic             first_mismatch;
   logic [SW-1:0]    skew_now;

   // Next-state computation for pointers, occupancies and sticky diagnostics
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave a variable unassigned and infer a latch.
      pop            = 1'b0;
      push_1         = 1'b0;
      push_2         = 1'b0;
      drop_1         = 1'b0;
      drop_2         = 1'b0;
      heads_differ   = 1'b0;
      first_mismatch = 1'b0;
      equiv_d        = equiv_q;
      mm_valid_d     = mm_valid_q;
      mm_idx_d       = mm_idx_q;
      cnt_d          = cnt_q;
      overflow_d     = overflow_q;
      count_mm_d     = count_mm_q;
      max_skew_d     = max_skew_q;

      // Both heads present: compare and retire the pair together
      pop = (occ_1_q != '0) && (occ_2_q != '0);

      // A push into a full FIFO survives only if the same edge frees a slot
      push_1 = retire_1_i && ((occ_1_q != FULL_OCC) || pop);
      push_2 = retire_2_i && ((occ_2_q != FULL_OCC) || pop);
      drop_1 = retire_1_i && !push_1;
      drop_2 = retire_2_i && !push_2;

      wr_1_d  = wr_1_q + AW'(push_1);
      wr_2_d  = wr_2_q + AW'(push_2);
      rd_1_d  = rd_1_q + AW'(pop);
      rd_2_d  = rd_2_q + AW'(pop);
      occ_1_d = occ_1_q + SW'(push_1) - SW'(pop);
      occ_2_d = occ_2_q + SW'(push_2) - SW'(pop);

      if (pop) begin
         heads_differ = (mem_1_q[rd_1_q] != mem_2_q[rd_2_q]);
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (heads_differ) begin
         equiv_d = 1'b0;
         if (!mm_valid_q) begin
            first_mismatch = 1'b1;
            mm_valid_d     = 1'b1;
            mm_idx_d       = cnt_q;
         end
      end

      if (drop_1 || drop_2) begin
         overflow_d = 1'b1;
         equiv_d    = 1'b0;
      end

      // End-of-run check looks at occupancy after this edge's push/pop
      if (done_i && (occ_1_d != occ_2_d)) begin
         count_mm_d = 1'b1;
         equiv_d    = 1'b0;
      end

      skew_now = (occ_1_d >= occ_2_d) ? (occ_1_d - occ_2_d) : (occ_2_d - occ_1_d);
      if (skew_now > max_skew_q) begin
         max_skew_d = skew_now;
      end
   end

   // Control and diagnostic registers; reset empties both FIFOs at once
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_1_q     <= '0;
         rd_1_q     <= '0;
         occ_1_q    <= '0;
         wr_2_q     <= '0;
         rd_2_q     <= '0;
         occ_2_q    <= '0;
         equiv_q    <= 1'b1;
         mm_valid_q <= 1'b0;
         mm_idx_q   <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         count_mm_q <= 1'b0;
         max_skew_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge state computed above, independent of statement order.
         wr_1_q     <= wr_1_d;
         rd_1_q     <= rd_1_d;
         occ_1_q    <= occ_1_d;
         wr_2_q     <= wr_2_d;
         rd_2_q     <= rd_2_d;
         occ_2_q    <= occ_2_d;
         equiv_q    <= equiv_d;
         mm_valid_q <= mm_valid_d;
         mm_idx_q   <= mm_idx_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
         count_mm_q <= count_mm_d;
         max_skew_q <= max_skew_d;
      end
   end

   // FIFO payload writes
   always_ff @(posedge clk_i) begin
      // NOTE: storage is not reset; occupancy gates every read, so stale
      // entries are never observed and the array stays plain RAM.
      if (push_1) begin
         mem_1_q[wr_1_q] <= obs_1_i;
      end
      if (push_2) begin
         mem_2_q[wr_2_q] <= obs_2_i;
      end
   end

   assign ctr_equiv_o      = equiv_q;
   assign mismatch_valid_o = mm_valid_q;
   assign mismatch_idx_o   = mm_idx_q;
   assign compared_cnt_o   = cnt_q;
   assign overflow_o       = overflow_q;
   assign count_mismatch_o = count_mm_q;
   assign max_skew_o       = max_skew_q;

`ifdef CTR_MISMATCH_TRACE_EN
   logic [OBS_W-1:0] cap_1_q, cap_1_d, cap_2_q, cap_2_d;

   // Latch both heads on the first mismatching compare only
   always_comb begin
      cap_1_d = cap_1_q;
      cap_2_d = cap_2_q;
      if (first_mismatch) begin
         cap_1_d = mem_1_q[rd_1_q];
         cap_2_d = mem_2_q[rd_2_q];
      end
   end

   // Capture registers, held until reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cap_1_q <= '0;
         cap_2_q <= '0;
      end else begin
         cap_1_q <= cap_1_d;
         cap_2_q <= cap_2_d;
      end
   end

   assign mismatch_obs_1_o = cap_1_q;
   assign mismatch_obs_2_o = cap_2_q;
`else
   assign mismatch_obs_1_o = '0;
   assign mismatch_obs_2_o = '0;
`endif

endmodule

// File: tb/tb_ctr_queue_checker.sv
// Testbench for ctr_queue_checker: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based reference model.
module tb_ctr_queue_checker;

   localparam int OBS_W = 16;
   localparam int DEPTH = 8;
   localparam int CNT_W = 5;
   localparam int SW    = $clog2(DEPTH) + 1;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   logic             clk_i;
   logic             rst_ni;
   logic             retire_1_i, retire_2_i, done_i;
   logic [OBS_W-1:0] obs_1_i, obs_2_i;
   logic             ctr_equiv_o, mismatch_valid_o, overflow_o, count_mismatch_o;
   logic [CNT_W-1:0] mismatch_idx_o, compared_cnt_o;
   logic [SW-1:0]    max_skew_o;
   logic [OBS_W-1:0] mismatch_obs_1_o, mismatch_obs_2_o;

   ctr_queue_checker #(.OBS_W(OBS_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .retire_1_i       (retire_1_i),
      .obs_1_i          (obs_1_i),
      .retire_2_i       (retire_2_i),
      .obs_2_i          (obs_2_i),
      .done_i           (done_i),
      .ctr_equiv_o      (ctr_equiv_o),
      .mismatch_valid_o (mismatch_valid_o),
      .mismatch_idx_o   (mismatch_idx_o),
      .compared_cnt_o   (compared_cnt_o),
      .overflow_o       (overflow_o),
      .count_mismatch_o (count_mismatch_o),
      .max_skew_o       (max_skew_o),
      .mismatch_obs_1_o (mismatch_obs_1_o),
      .mismatch_obs_2_o (mismatch_obs_2_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int    errors = 0;
   int    checks = 0;
   string phase  = "init";

   // Reference model: two observation queues plus expected diagnostics
   logic [OBS_W-1:0] q1 [$];
   logic [OBS_W-1:0] q2 [$];
   bit               e_equiv, e_mmv, e_ovf, e_cmm;
   int               e_idx, e_cnt, e_skew;
   logic [OBS_W-1:0] e_cap1, e_cap2;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h", phase, tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q1.delete();
      q2.delete();
      e_equiv = 1'b1;
      e_mmv   = 1'b0;
      e_ovf   = 1'b0;
      e_cmm   = 1'b0;
      e_idx   = 0;
      e_cnt   = 0;
      e_skew  = 0;
      e_cap1  = '0;
      e_cap2  = '0;
   endtask

   task automatic model_step(input bit r1, input logic [OBS_W-1:0] o1,
                             input bit r2, input logic [OBS_W-1:0] o2, input bit d);
      bit               pop;
      bit               acc1, acc2;
      logic [OBS_W-1:0] h1, h2;
      int               diff;
      pop  = (q1.size() > 0) && (q2.size() > 0);
      acc1 = r1 && ((q1.size() < DEPTH) || pop);
      acc2 = r2 && ((q2.size() < DEPTH) || pop);
      if (pop) begin
         h1 = q1.pop_front();
         h2 = q2.pop_front();
         if (h1 != h2) begin
            e_equiv = 1'b0;
            if (!e_mmv) begin
               e_mmv  = 1'b1;
               e_idx  = e_cnt;
               e_cap1 = h1;
               e_cap2 = h2;
            end
         end
         if (e_cnt < CNT_SAT) e_cnt++;
      end
      if (acc1) q1.push_back(o1);
      if (acc2) q2.push_back(o2);
      if ((r1 && !acc1) || (r2 && !acc2)) begin
         e_ovf   = 1'b1;
         e_equiv = 1'b0;
      end
      if (d && (q1.size() != q2.size())) begin
         e_cmm   = 1'b1;
         e_equiv = 1'b0;
      end
      diff = q1.size() - q2.size();
      if (diff < 0) diff = -diff;
      if (diff > e_skew) e_skew = diff;
   endtask

   task automatic check_all();
      check("equiv",    ctr_equiv_o,      e_equiv);
      check("mm_valid", mismatch_valid_o, e_mmv);
      check("mm_idx",   mismatch_idx_o,   e_idx);
      check("cnt",      compared_cnt_o,   e_cnt);
      check("overflow", overflow_o,       e_ovf);
      check("cnt_mm",   count_mismatch_o, e_cmm);
      check("skew",     max_skew_o,       e_skew);
`ifdef CTR_MISMATCH_TRACE_EN
      check("cap1",     mismatch_obs_1_o, e_cap1);
      check("cap2",     mismatch_obs_2_o, e_cap2);
`else
      check("cap1",     mismatch_obs_1_o, 0);
      check("cap2",     mismatch_obs_2_o, 0);
`endif
   endtask

   // One clock: drive, advance past the edge, update model, compare
   task automatic step(input bit r1, input logic [OBS_W-1:0] o1,
                       input bit r2, input logic [OBS_W-1:0] o2, input bit d);
      retire_1_i = r1;
      obs_1_i    = o1;
      retire_2_i = r2;
      obs_2_i    = o2;
      done_i     = d;
      @(posedge clk_i);
      model_step(r1, o1, r2, o2, d);
      #1;
      check_all();
   endtask

   // Assert reset away from any edge, check immediately, then release
   task automatic do_reset();
      @(negedge clk_i);
      #2;
      rst_ni     = 1'b0;
      retire_1_i = 1'b0;
      retire_2_i = 1'b0;
      done_i     = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      step(0, '0, 0, '0, 0);
   endtask

   initial begin
      int n1, n2, p1, p2;
      rst_ni     = 1'b0;
      retire_1_i = 1'b0;
      retire_2_i = 1'b0;
      done_i     = 1'b0;
      obs_1_i    = '0;
      obs_2_i    = '0;
      model_reset();

      phase = "reset";
      do_reset();
      check("rst_equiv", ctr_equiv_o, 1);
      check("rst_cnt", compared_cnt_o, 0);

      // Lock-step 0x1..0x10, done on the last push with equal occupancy
      phase = "lockstep";
      for (int i = 1; i <= 16; i++) step(1, OBS_W'(i), 1, OBS_W'(i), i == 16);
      step(0, '0, 0, '0, 1);
      check("ls_cnt", compared_cnt_o, 16);
      check("ls_equiv", ctr_equiv_o, 1);
      check("ls_skew", max_skew_o, 0);
      check("ls_cmm", count_mismatch_o, 0);

      // Skew: copy 1 at cycles 0-4, copy 2 at cycles 6-10
      phase = "skew";
      do_reset();
      for (int c = 0; c <= 11; c++) begin
         step(c < 5, OBS_W'(16'h100 + c), (c >= 6) && (c <= 10), OBS_W'(16'h100 + c - 6), 0);
         if (c == 6) check("sk_cnt6", compared_cnt_o, 0);
         if (c == 7) check("sk_cnt7", compared_cnt_o, 1);
      end
      check("sk_cnt", compared_cnt_o, 5);
      check("sk_skew", max_skew_o, 5);
      check("sk_equiv", ctr_equiv_o, 1);

      // Push+pop on full FIFO is not an overflow; then a real overflow
      phase = "full";
      do_reset();
      for (int c = 0; c < DEPTH; c++) step(1, OBS_W'(16'h200 + c), 0, '0, 0);
      step(0, '0, 1, 16'h200, 0);
      step(1, OBS_W'(16'h200 + DEPTH), 1, 16'h201, 0);
      check("pp_ovf", overflow_o, 0);
      check("pp_equiv", ctr_equiv_o, 1);
      for (int v = 16'h202; v <= 16'h200 + DEPTH; v++) step(0, '0, 1, OBS_W'(v), 0);
      for (int c = 0; c < 10; c++) step(0, '0, 0, '0, 0);
      check("pp_cnt", compared_cnt_o, DEPTH + 1);
      for (int c = 0; c <= DEPTH; c++) begin
         step(1, OBS_W'(16'h300 + c), 0, '0, 0);
         if (c == DEPTH - 1) check("of_before", overflow_o, 0);
      end
      check("of_ovf", overflow_o, 1);
      check("of_equiv", ctr_equiv_o, 0);

      // Mismatch on the third pair, then two more
      phase = "mismatch";
      do_reset();
      step(1, 16'h1, 1, 16'h1, 0);
      step(1, 16'h2, 1, 16'h2, 0);
      step(1, 16'hA, 1, 16'hB, 0);
      check("mm_pre_equiv", ctr_equiv_o, 1);
      step(1, 16'h4, 1, 16'h5, 0);
      check("mm_equiv", ctr_equiv_o, 0);
      check("mm_idx2", mismatch_idx_o, 2);
      step(1, 16'h5, 1, 16'h6, 0);
      step(0, '0, 0, '0, 0);
      step(0, '0, 0, '0, 0);
      check("mm_idx_hold", mismatch_idx_o, 2);
`ifdef CTR_MISMATCH_TRACE_EN
      check("mm_obs1", mismatch_obs_1_o, 16'hA);
      check("mm_obs2", mismatch_obs_2_o, 16'hB);
`endif

      // Count check: 3 vs 2 then done
      phase = "count";
      do_reset();
      step(1, 16'h1, 1, 16'h1, 0);
      step(1, 16'h2, 1, 16'h2, 0);
      step(1, 16'h3, 0, '0, 0);
      check("cc_pre", count_mismatch_o, 0);
      step(0, '0, 0, '0, 1);
      check("cc_cmm", count_mismatch_o, 1);
      check("cc_equiv", ctr_equiv_o, 0);

      // Randomized traffic with occasional corruption, done and bursts
      phase = "random";
      do_reset();
      n1 = 0;
      n2 = 0;
      p1 = 50;
      p2 = 50;
      for (int c = 0; c < 600; c++) begin
         bit               r1, r2, d;
         logic [OBS_W-1:0] o1, o2;
         if (c % 40 == 0) begin
            p1 = int'($urandom_range(10, 90));
            p2 = int'($urandom_range(10, 90));
         end
         if (c == 300) begin
            do_reset();
            n1 = 0;
            n2 = 0;
         end
         r1 = ($urandom_range(0, 99) < p1);
         r2 = ($urandom_range(0, 99) < p2);
         d  = ($urandom_range(0, 49) == 0);
         o1 = OBS_W'(n1 * 7 + 3);
         o2 = OBS_W'(n2 * 7 + 3);
         if ($urandom_range(0, 29) == 0) o2 = o2 ^ OBS_W'(1 << $urandom_range(0, OBS_W - 1));
         if (r1) n1++;
         if (r2) n2++;
         step(r1, o1, r2, o2, d);
      end

      // Reset with 3 entries queued, then one lock-step pair
      phase = "midreset";
      do_reset();
      for (int c = 0; c < 3; c++) step(1, OBS_W'(16'h40 + c), 0, '0, 0);
      do_reset();
      check("mr_equiv", ctr_equiv_o, 1);
      check("mr_skew", max_skew_o, 0);
      step(1, 16'h55, 1, 16'h55, 0);
      step(0, '0, 0, '0, 0);
      step(0, '0, 0, '0, 0);
      check("mr_cnt", compared_cnt_o, 1);
      check("mr_equiv2", ctr_equiv_o, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
